// File: rtl/fetch_arb_pkg.sv
// Shared constants, FSM encoding and small helpers for the fetch slot arbiter.
package fetch_arb_pkg;

  localparam int unsigned NUM_WF    = 40;
  localparam int unsigned WFID_W    = 6;
  localparam int unsigned MAX_OUTST = 2;
  localparam int unsigned CNT_W     = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } fsm_state_e;

  // Next slot id after 'id', wrapping the last slot back to slot 0.
  function automatic logic [WFID_W-1:0] wfid_inc(input logic [WFID_W-1:0] id);
    if (id == WFID_W'(NUM_WF - 1)) begin
      return '0;
    end
    return id + WFID_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible slot at or above rr_ptr,
// wrapping from the last slot back to slot 0.
module rr_pick
  import fetch_arb_pkg::*;
(
  input  logic [NUM_WF-1:0] eligible,
  input  logic [WFID_W-1:0] rr_ptr,
  output logic [WFID_W-1:0] grant_wfid,
  output logic              grant_any
);

  localparam int unsigned IdxW = WFID_W + 1;
  typedef logic [IdxW-1:0] idx_t;

  // Scan offsets 0..NUM_WF-1 from the pointer; the first hit wins.
  always_comb begin : pick
    idx_t idx;
    grant_any  = 1'b0;
    grant_wfid = '0;
    idx        = '0;
    for (int k = 0; k < int'(NUM_WF); k++) begin
      idx = idx_t'(rr_ptr) + idx_t'(k);
      // rr_ptr < NUM_WF, so a single subtraction is enough to wrap.
      if (idx >= idx_t'(NUM_WF)) begin
        idx = idx - idx_t'(NUM_WF);
      end
      if (!grant_any && eligible[idx[WFID_W-1:0]]) begin
        grant_any  = 1'b1;
        grant_wfid = idx[WFID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fetch_slot_arbiter.sv
// Fetch slot arbiter: round-robin choice of the wavefront slot that issues the
// next instruction fetch, with a per-slot cap on un-returned fetches.
// Optional statistics counters are built when FETCH_ARB_STATS_EN is defined.
module fetch_slot_arbiter
  import fetch_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_WF-1:0] wf_active,
  input  logic [NUM_WF-1:0] wave_stop_fetch,
  input  logic              slot_clr_en,
  input  logic [WFID_W-1:0] slot_clr_wfid,
  input  logic              buff_ack,
  input  logic              ret_valid,
  input  logic [WFID_W-1:0] ret_wfid,
`ifdef FETCH_ARB_STATS_EN
  output logic [31:0]       stat_grants,
  output logic [31:0]       stat_stalls,
  input  logic              stat_clr,
`endif
  output logic              fetch_valid,
  output logic [WFID_W-1:0] fetch_wfid,
  output logic              outst_err
);

  fsm_state_e        state_q, state_d;
  logic [WFID_W-1:0] fetch_wfid_q, fetch_wfid_d;
  logic [WFID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  cnt_q [NUM_WF];
  logic [CNT_W-1:0]  cnt_d [NUM_WF];
  logic              outst_err_q, outst_err_d;

  logic [NUM_WF-1:0] eligible;
  logic [WFID_W-1:0] grant_wfid;
  logic              grant_any;
  logic              ack_fire;

  assign ack_fire = (state_q == ST_REQ) && buff_ack;

  // A slot may be picked when live, not stopped and below its credit cap.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < int'(NUM_WF); i++) begin
      eligible[i] = wf_active[i] && !wave_stop_fetch[i] &&
                    (cnt_q[i] < CNT_W'(MAX_OUTST));
    end
  end

  rr_pick u_rr_pick (
    .eligible   (eligible),
    .rr_ptr     (rr_ptr_q),
    .grant_wfid (grant_wfid),
    .grant_any  (grant_any)
  );

  // Grant FSM: latch a pick in IDLE, hold the request in REQ until acked.
  always_comb begin
    state_d      = state_q;
    fetch_wfid_d = fetch_wfid_q;
    rr_ptr_d     = rr_ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          fetch_wfid_d = grant_wfid;
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        // The request is never withdrawn, even if the slot stops meanwhile.
        if (buff_ack) begin
          rr_ptr_d = wfid_inc(fetch_wfid_q);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outstanding-fetch counters: clear beats ack/return; ack+return cancel.
  always_comb begin
    outst_err_d = outst_err_q;
    for (int i = 0; i < int'(NUM_WF); i++) begin
      logic inc;
      logic dec;
      inc      = ack_fire && (fetch_wfid_q == WFID_W'(i));
      dec      = ret_valid && (ret_wfid == WFID_W'(i));
      cnt_d[i] = cnt_q[i];
      if (slot_clr_en && (slot_clr_wfid == WFID_W'(i))) begin
        cnt_d[i] = '0;
      end else if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec && !inc) begin
        if (cnt_q[i] == '0) begin
          outst_err_d = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
      end
    end
  end

  // State, pointer, counter and error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      fetch_wfid_q <= '0;
      rr_ptr_q     <= '0;
      outst_err_q  <= 1'b0;
      for (int i = 0; i < int'(NUM_WF); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      fetch_wfid_q <= fetch_wfid_d;
      rr_ptr_q     <= rr_ptr_d;
      outst_err_q  <= outst_err_d;
      for (int i = 0; i < int'(NUM_WF); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign fetch_valid = (state_q == ST_REQ);
  assign fetch_wfid  = fetch_wfid_q;
  assign outst_err   = outst_err_q;

`ifdef FETCH_ARB_STATS_EN
  logic [31:0] stat_grants_q;
  logic [31:0] stat_stalls_q;
  logic        credit_stall;

  // Some slot wants to fetch but every such slot is out of credits.
  assign credit_stall = (|(wf_active & ~wave_stop_fetch)) && !(|eligible);

  // Saturating statistics counters with synchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_grants_q <= '0;
      stat_stalls_q <= '0;
    end else if (stat_clr) begin
      stat_grants_q <= '0;
      stat_stalls_q <= '0;
    end else begin
      if (ack_fire && (stat_grants_q != '1)) begin
        stat_grants_q <= stat_grants_q + 32'd1;
      end
      if (credit_stall && (stat_stalls_q != '1)) begin
        stat_stalls_q <= stat_stalls_q + 32'd1;
      end
    end
  end

  assign stat_grants = stat_grants_q;
  assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_fetch_slot_arbiter.sv
// Self-checking bench for fetch_slot_arbiter. Expected grant ids are queued
// when the stimulus is set up and popped as each request appears.
module tb_fetch_slot_arbiter;
  import fetch_arb_pkg::*;

  logic              clk;
  logic              rst;
  logic [NUM_WF-1:0] wf_active;
  logic [NUM_WF-1:0] wave_stop_fetch;
  logic              slot_clr_en;
  logic [WFID_W-1:0] slot_clr_wfid;
  logic              buff_ack;
  logic              ret_valid;
  logic [WFID_W-1:0] ret_wfid;
  logic              fetch_valid;
  logic [WFID_W-1:0] fetch_wfid;
  logic              outst_err;
`ifdef FETCH_ARB_STATS_EN
  logic [31:0]       stat_grants;
  logic [31:0]       stat_stalls;
  logic              stat_clr;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];

  fetch_slot_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .wf_active       (wf_active),
    .wave_stop_fetch (wave_stop_fetch),
    .slot_clr_en     (slot_clr_en),
    .slot_clr_wfid   (slot_clr_wfid),
    .buff_ack        (buff_ack),
    .ret_valid       (ret_valid),
    .ret_wfid        (ret_wfid),
`ifdef FETCH_ARB_STATS_EN
    .stat_grants     (stat_grants),
    .stat_stalls     (stat_stalls),
    .stat_clr        (stat_clr),
`endif
    .fetch_valid     (fetch_valid),
    .fetch_wfid      (fetch_wfid),
    .outst_err       (outst_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst             = 1'b0;
    wf_active       = '0;
    wave_stop_fetch = '0;
    slot_clr_en     = 1'b0;
    slot_clr_wfid   = '0;
    buff_ack        = 1'b0;
    ret_valid       = 1'b0;
    ret_wfid        = '0;
`ifdef FETCH_ARB_STATS_EN
    stat_clr        = 1'b0;
`endif
    exp_q.delete();
    tick();
    tick();
    check_eq("rst_valid", 32'(fetch_valid), 32'd0);
    check_eq("rst_wfid", 32'(fetch_wfid), 32'd0);
    check_eq("rst_err", 32'(outst_err), 32'd0);
    rst = 1'b1;
  endtask

  // Serve the next request: compare with the scoreboard, hold it 'hold' cycles
  // (raising the slot's stop bit at cycle stop_at), then ack it.
  task automatic grant_one(input int hold, input int stop_at, input bit ret_en, input bit deact);
    int exp_id;
    int waited;
    exp_id = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    waited = 0;
    while (!fetch_valid && waited < 40) begin
      tick();
      waited++;
    end
    if (!fetch_valid) begin
      check_eq("grant_timeout", 32'd0, 32'd1);
      return;
    end
    check_eq("grant_wfid", 32'(fetch_wfid), 32'(exp_id));
    for (int h = 0; h < hold; h++) begin
      if (h == stop_at) wave_stop_fetch[exp_id] = 1'b1;
      tick();
      check_eq("hold_valid", 32'(fetch_valid), 32'd1);
      check_eq("hold_wfid", 32'(fetch_wfid), 32'(exp_id));
    end
    buff_ack = 1'b1;
    if (ret_en) begin
      ret_valid = 1'b1;
      ret_wfid  = WFID_W'(exp_id);
    end
    if (deact) wf_active = '0;
    tick();
    buff_ack  = 1'b0;
    ret_valid = 1'b0;
    check_eq("drop_valid", 32'(fetch_valid), 32'd0);
  endtask

  task automatic expect_idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check_eq("idle_valid", 32'(fetch_valid), 32'd0);
    end
  endtask

  task automatic ret_pulse(input int id);
    ret_valid = 1'b1;
    ret_wfid  = WFID_W'(id);
    tick();
    ret_valid = 1'b0;
  endtask

  initial begin
    // 1: single slot runs out of credits after MAX_OUTST grants.
    do_reset();
    wf_active[5] = 1'b1;
    exp_q.push_back(5);
    exp_q.push_back(5);
    grant_one(1, -1, 1'b0, 1'b0);
    grant_one(0, -1, 1'b0, 1'b0);
    expect_idle(5);

    // 2: round-robin order with wrap from slot 39.
    do_reset();
    wf_active[3]  = 1'b1;
    wf_active[10] = 1'b1;
    wf_active[39] = 1'b1;
    exp_q.push_back(3);
    exp_q.push_back(10);
    exp_q.push_back(39);
    exp_q.push_back(3);
    for (int i = 0; i < 4; i++) grant_one(0, -1, 1'b0, 1'b0);

    // 3: request held stable while stalled and stopped; one more credit left.
    do_reset();
    wf_active[7] = 1'b1;
    exp_q.push_back(7);
    grant_one(5, 2, 1'b0, 1'b0);
    wave_stop_fetch = '0;
    exp_q.push_back(7);
    grant_one(0, -1, 1'b0, 1'b0);
    expect_idle(4);

    // 4: ack+return cancel, then underflow sets the sticky error.
    do_reset();
    wf_active[2] = 1'b1;
    exp_q.push_back(2);
    exp_q.push_back(2);
    grant_one(0, -1, 1'b0, 1'b0);
    grant_one(0, -1, 1'b1, 1'b1);
    ret_pulse(2);
    check_eq("ret1_err", 32'(outst_err), 32'd0);
    ret_pulse(2);
    check_eq("ret2_err", 32'(outst_err), 32'd1);
    tick();
    tick();
    check_eq("err_sticky", 32'(outst_err), 32'd1);

    // 5: async reset in the middle of a pending request.
    do_reset();
    ret_pulse(9);
    check_eq("pre_rst_err", 32'(outst_err), 32'd1);
    wf_active[9] = 1'b1;
    exp_q.push_back(9);
    grant_one(0, -1, 1'b0, 1'b0);
    tick();
    check_eq("pend_valid", 32'(fetch_valid), 32'd1);
    check_eq("pend_wfid", 32'(fetch_wfid), 32'd9);
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_valid", 32'(fetch_valid), 32'd0);
    check_eq("async_wfid", 32'(fetch_wfid), 32'd0);
    check_eq("async_err", 32'(outst_err), 32'd0);
    tick();
    rst = 1'b1;
    exp_q.push_back(9);
    exp_q.push_back(9);
    grant_one(0, -1, 1'b0, 1'b0);
    grant_one(0, -1, 1'b0, 1'b0);
    expect_idle(4);

`ifdef FETCH_ARB_STATS_EN
    // 6: fill every slot to the cap, then count credit-starved cycles.
    do_reset();
    wf_active = '1;
    for (int r = 0; r < int'(MAX_OUTST); r++) begin
      for (int i = 0; i < int'(NUM_WF); i++) exp_q.push_back(i);
    end
    for (int i = 0; i < int'(NUM_WF * MAX_OUTST); i++) grant_one(0, -1, 1'b0, 1'b0);
    check_eq("stat_grants", stat_grants, 32'(NUM_WF * MAX_OUTST));
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check_eq("clr_grants", stat_grants, 32'd0);
    check_eq("clr_stalls", stat_stalls, 32'd0);
    for (int i = 0; i < 8; i++) tick();
    check_eq("stat_stalls", stat_stalls, 32'd8);
    check_eq("stall_grants", stat_grants, 32'd0);
    check_eq("stall_valid", 32'(fetch_valid), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
